iob_gpio_evt_ctrl: RTL and testbench
====================================

IOB_GPIO_EVT_CTRL -- requirements
Module: iob_gpio_evt_ctrl

Interface
REQ-001 Parameter N_CH, default 4: number of sensor channels, range 2..32.
REQ-002 Parameter DEB_W, default 8: width of the debounce counter and of deb_cycles.
REQ-003 Parameter ID_W, default $clog2(N_CH): width of evt_id.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst  input  1: synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 sensor  input  N_CH: asynchronous raw sensor levels, one per channel.
REQ-007 en_mask  input  N_CH: per-channel arm bit; 1 means rising events are captured.
REQ-008 deb_cycles  input  DEB_W: debounce stability count D; treated as quasi-static.
REQ-009 clr_all  input  1: single-cycle pulse that clears all pending and overrun state.
REQ-010 evt_valid  output  1: registered; an event is presented on evt_id.
REQ-011 evt_id  output  ID_W: registered channel index of the presented event.
REQ-012 evt_ready  input  1: consumer accepts the presented event.
REQ-013 pend  output  N_CH: registered sticky pending flags.
REQ-014 overrun  output  N_CH: registered sticky flags; an event arrived while the channel was already pending.
REQ-015 irq  output  1: registered; equals OR of pend, delayed by one cycle.

Function
REQ-016 Each sensor bit shall pass through a 2-flop synchronizer (s_sync) before any other use.
REQ-017 Debounce counter: cleared when s_sync equals the filtered level (filt); otherwise incremented each cycle.
REQ-018 When the counter equals D while s_sync differs from filt, filt shall take s_sync and the counter shall clear.
REQ-019 Latency: D=0 gives a filt change 3 cycles after a sensor edge; in general the latency is D+3 cycles.
REQ-020 A glitch shorter than D+1 synchronized cycles shall not change filt.
REQ-021 Event: a filt 0->1 transition on channel i with en_mask[i]=1 shall set pend[i] on the next edge.
REQ-022 Falling edges of filt and edges on masked channels shall be ignored.
REQ-023 Clearing en_mask[i] shall not clear an existing pend[i].
REQ-024 An event on channel i while pend[i]=1 and not being cleared in that cycle shall set overrun[i]; pend[i] stays 1.
REQ-025 Arbiter FSM has two states, IDLE and PRESENT.
REQ-026 IDLE, pend nonzero: grant the first set pend bit at or after rr_ptr, wrapping modulo N_CH.
REQ-027 On a grant: register evt_id, set evt_valid=1, enter PRESENT.
REQ-028 IDLE, pend zero: remain in IDLE with evt_valid=0.
REQ-029 PRESENT: evt_valid=1 and evt_id shall hold stable until evt_valid&evt_ready.
REQ-030 On that handshake: clear pend[evt_id], set rr_ptr to (evt_id+1) mod N_CH, drive evt_valid=0, return to IDLE.
REQ-031 Maximum throughput is one event per 2 cycles.
REQ-032 A new event on channel evt_id in the handshake cycle shall leave pend=1 and shall not set overrun.
REQ-033 clr_all=1: clear pend, overrun, evt_valid and rr_ptr; enter IDLE.
REQ-034 clr_all shall take priority over same-cycle events and handshakes.
REQ-035 clr_all shall not alter the synchronizer, filt or debounce counters.
REQ-036 evt_ready while evt_valid=0 shall have no effect.

Reset
REQ-037 rst=0 at a clock edge: all synchronizer flops, filt, counters, pend, overrun, rr_ptr, evt_id, evt_valid and irq become 0; FSM enters IDLE.
REQ-038 Reset mid-handshake shall discard the presented event.
REQ-039 A sensor held high through reset shall produce one event D+3 cycles after release, if armed.

Verification
REQ-040 N_CH=4, D=3, en_mask=4'hF, sensor[2] rises and holds -> pend[2]=1 at edge 7, evt_valid=1/evt_id=2 at edge 8, irq=1 at edge 8.
REQ-041 D=3, sensor[0] pulses high for 3 cycles -> no pend or evt_valid; a 4-cycle pulse -> pend[0]=1.
REQ-042 pend=4'b1011, rr_ptr=0, evt_ready held 1 -> grant order 0,1,3, one grant per 2 cycles, then evt_valid=0.
REQ-043 evt_ready=0, second rising event on the presented channel 1 -> overrun[1]=1; evt_id stays 1; after clr_all, pend=0, overrun=0 and evt_valid=0 next cycle.
REQ-044 en_mask[3]=0 with a sensor[3] edge -> pend[3]=0; a rst=0 pulse in PRESENT -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/iob_gpio_evt_ctrl.sv
// GPIO event controller: per-channel sync + debounce, rising-edge capture into sticky pend/overrun,
// and a round-robin valid/ready presenter for pending channel ids.
module iob_gpio_evt_ctrl #(
  parameter int N_CH  = 4,
  parameter int DEB_W = 8,
  parameter int ID_W  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   sensor,
  input  logic [N_CH-1:0]   en_mask,
  input  logic [DEB_W-1:0]  deb_cycles,
  input  logic              clr_all,
  output logic              evt_valid,
  output logic [ID_W-1:0]   evt_id,
  input  logic              evt_ready,
  output logic [N_CH-1:0]   pend,
  output logic [N_CH-1:0]   overrun,
  output logic              irq
);

  typedef enum logic {IDLE, PRESENT} state_t;

  logic [N_CH-1:0]  sync1_q;
  logic [N_CH-1:0]  s_sync_q;
  logic [N_CH-1:0]  filt_q, filt_d;
  logic [N_CH-1:0]  filt_dly_q;
  logic [DEB_W-1:0] cnt_q [N_CH];
  logic [DEB_W-1:0] cnt_d [N_CH];

  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  overrun_q, overrun_d;
  logic             irq_q;

  state_t           state_q;
  logic             evt_valid_q;
  logic [ID_W-1:0]  evt_id_q;
  logic [ID_W-1:0]  rr_ptr_q;

  logic             handshake;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  id_onehot;
  logic [N_CH-1:0]  clr_vec;
  logic [N_CH-1:0]  hi_mask;
  logic [N_CH-1:0]  pend_hi;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  rr_next;

  // Input synchronizer and debounce state; untouched by clr_all.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q    <= '0;
      s_sync_q   <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      cnt_q      <= '{default: '0};
    end else begin
      sync1_q    <= sensor;
      s_sync_q   <= sync1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      cnt_q      <= cnt_d;
    end
  end

  // The counter tracks how long s_sync has disagreed with filt; filt follows after D+1 such cycles.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (s_sync_q[i] != filt_q[i]) begin
        if (cnt_q[i] == deb_cycles) begin
          filt_d[i] = s_sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  assign handshake = evt_valid_q & evt_ready;
  assign rise      = filt_q & ~filt_dly_q & en_mask;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      id_onehot[i] = (evt_id_q == ID_W'(i));
    end
  end

  assign clr_vec = handshake ? id_onehot : '0;

  // A same-cycle event on the channel being acknowledged re-arms it without flagging overrun.
  always_comb begin
    if (clr_all) begin
      pend_d    = '0;
      overrun_d = '0;
    end else begin
      pend_d    = (pend_q & ~clr_vec) | rise;
      overrun_d = overrun_q | (rise & pend_q & ~clr_vec);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q    <= '0;
      overrun_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      irq_q     <= |pend_q;
    end
  end

  // Round-robin pick: lowest pending index at or above rr_ptr, else lowest pending overall.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      hi_mask[i] = (i >= int'(rr_ptr_q));
    end
    pend_hi   = pend_q & hi_mask;
    grant_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) grant_idx = ID_W'(i);
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend_hi[i]) grant_idx = ID_W'(i);
    end
  end

  assign rr_next = (evt_id_q == ID_W'(N_CH - 1)) ? '0 : evt_id_q + ID_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else if (clr_all) begin
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pend_q) begin
            evt_id_q    <= grant_idx;
            evt_valid_q <= 1'b1;
            state_q     <= PRESENT;
          end
        end
        PRESENT: begin
          if (evt_ready) begin
            evt_valid_q <= 1'b0;
            rr_ptr_q    <= rr_next;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          evt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign pend      = pend_q;
  assign overrun   = overrun_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_iob_gpio_evt_ctrl.sv
// Bench for iob_gpio_evt_ctrl: directed scenarios plus randomized traffic against a window-based reference model.
module tb_iob_gpio_evt_ctrl;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  sensor;
  logic [N-1:0]  en_mask;
  logic [DW-1:0] deb_cycles;
  logic          clr_all;
  logic          evt_valid;
  logic [IW-1:0] evt_id;
  logic          evt_ready;
  logic [N-1:0]  pend;
  logic [N-1:0]  overrun;
  logic          irq;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [N-1:0] sync1_m, ssync_m, filt_m, rose_m, pend_m, ovr_m;
  bit   [7:0]   hist_m [N];
  bit           pres_m, irq_m;
  int           id_m, rr_m;

  always #5 clk = ~clk;

  iob_gpio_evt_ctrl #(.N_CH(N), .DEB_W(DW)) dut (
    .clk(clk), .rst(rst), .sensor(sensor), .en_mask(en_mask), .deb_cycles(deb_cycles),
    .clr_all(clr_all), .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready),
    .pend(pend), .overrun(overrun), .irq(irq)
  );

  // filt flips once the last D+1 synchronized samples all disagree with it.
  task automatic model_step();
    logic [N-1:0] ev, pold, newrose;
    bit hs, clr, diff_all;
    int j;
    if (!rst) begin
      sync1_m = '0; ssync_m = '0; filt_m = '0; rose_m = '0;
      pend_m = '0; ovr_m = '0; pres_m = 0; id_m = 0; rr_m = 0; irq_m = 0;
      for (int i = 0; i < N; i++) hist_m[i] = '0;
    end else begin
      ev      = rose_m & en_mask;
      pold    = pend_m;
      newrose = '0;
      for (int i = 0; i < N; i++) begin
        hist_m[i] = {hist_m[i][6:0], ssync_m[i]};
        diff_all  = 1;
        for (int k = 0; k <= int'(deb_cycles); k++)
          if (hist_m[i][k] == filt_m[i]) diff_all = 0;
        if (diff_all) begin
          filt_m[i]  = ~filt_m[i];
          newrose[i] = filt_m[i];
        end
      end
      ssync_m = sync1_m;
      sync1_m = sensor;
      rose_m  = newrose;
      irq_m   = |pold;
      hs      = pres_m && evt_ready;
      if (clr_all) begin
        pend_m = '0; ovr_m = '0; pres_m = 0; rr_m = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          clr = hs && (id_m == i);
          if (ev[i] && pold[i] && !clr) ovr_m[i] = 1'b1;
          pend_m[i] = (pold[i] && !clr) || ev[i];
        end
        if (pres_m) begin
          if (hs) begin
            pres_m = 0;
            rr_m   = (id_m + 1) % N;
          end
        end else if (pold != '0) begin
          for (int k = N - 1; k >= 0; k--) begin
            j = (rr_m + k) % N;
            if (pold[j]) id_m = j;
          end
          pres_m = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; sensor = '0; clr_all = 1'b0; evt_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    en_mask = '1; deb_cycles = 8'd3;
    do_reset();
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
    n_vec++; if (evt_id !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", evt_id); end
    n_vec++; if (pend !== 4'b0000) begin n_err++; $display("FAIL reset_pend: got %b want 0000", pend); end
    n_vec++; if (overrun !== 4'b0000) begin n_err++; $display("FAIL reset_ovr: got %b want 0000", overrun); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
  endtask

  task automatic test_latency();
    en_mask = 4'hF; deb_cycles = 8'd3;
    do_reset();
    sensor = 4'b0100;
    repeat (6) tick();
    n_vec++; if (pend !== 4'b0000) begin n_err++; $display("FAIL lat_pend_e6: got %b want 0000", pend); end
    tick();
    n_vec++; if (pend !== 4'b0100) begin n_err++; $display("FAIL lat_pend_e7: got %b want 0100", pend); end
    n_vec++; if (evt_valid !== 1'b0 || irq !== 1'b0) begin n_err++; $display("FAIL lat_e7_valid_irq: got %b/%b want 0/0", evt_valid, irq); end
    tick();
    n_vec++; if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin n_err++; $display("FAIL lat_e8_evt: got v=%b id=%0d want v=1 id=2", evt_valid, evt_id); end
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL lat_e8_irq: got %b want 1", irq); end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_vec++; if (evt_valid !== 1'b0 || pend !== 4'b0000) begin n_err++; $display("FAIL lat_ack: got v=%b pend=%b want v=0 pend=0000", evt_valid, pend); end
    sensor = 4'b0000;
    repeat (10) tick();
    n_vec++; if (pend !== 4'b0000 || evt_valid !== 1'b0) begin n_err++; $display("FAIL lat_fall_ignored: got pend=%b v=%b want 0000/0", pend, evt_valid); end
  endtask

  task automatic test_glitch();
    en_mask = 4'hF; deb_cycles = 8'd3;
    do_reset();
    sensor = 4'b0001;
    repeat (3) tick();
    sensor = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_vec++; if (pend !== 4'b0000 || evt_valid !== 1'b0) begin n_err++; $display("FAIL glitch3_c%0d: got pend=%b v=%b want 0000/0", c, pend, evt_valid); end
    end
    sensor = 4'b0001;
    repeat (4) tick();
    sensor = 4'b0000;
    repeat (3) tick();
    n_vec++; if (pend !== 4'b0001) begin n_err++; $display("FAIL glitch4_pend: got %b want 0001", pend); end
  endtask

  task automatic test_rr_order();
    bit exp_v [7];
    int exp_id [7];
    exp_v  = '{1, 0, 1, 0, 1, 0, 0};
    exp_id = '{0, 0, 1, 1, 3, 3, 3};
    en_mask = 4'hF; deb_cycles = 8'd3;
    do_reset();
    sensor = 4'b1011; evt_ready = 1'b1;
    repeat (7) tick();
    n_vec++; if (pend !== 4'b1011 || evt_valid !== 1'b0) begin n_err++; $display("FAIL rr_setup: got pend=%b v=%b want 1011/0", pend, evt_valid); end
    for (int c = 0; c < 7; c++) begin
      tick();
      n_vec++;
      if (evt_valid !== exp_v[c] || (exp_v[c] && evt_id !== IW'(exp_id[c]))) begin
        n_err++; $display("FAIL rr_step%0d: got v=%b id=%0d want v=%b id=%0d", c, evt_valid, evt_id, exp_v[c], exp_id[c]);
      end
    end
    n_vec++; if (pend !== 4'b0000) begin n_err++; $display("FAIL rr_drained: got %b want 0000", pend); end
    evt_ready = 1'b0;
  endtask

  task automatic test_overrun_clr();
    en_mask = 4'hF; deb_cycles = 8'd3;
    do_reset();
    sensor = 4'b0010;
    repeat (8) tick();
    n_vec++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin n_err++; $display("FAIL ovr_first: got v=%b id=%0d want 1/1", evt_valid, evt_id); end
    sensor = 4'b0000;
    repeat (8) tick();
    sensor = 4'b0010;
    repeat (8) tick();
    n_vec++; if (overrun !== 4'b0010 || pend !== 4'b0010) begin n_err++; $display("FAIL ovr_set: got ovr=%b pend=%b want 0010/0010", overrun, pend); end
    n_vec++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin n_err++; $display("FAIL ovr_hold: got v=%b id=%0d want 1/1", evt_valid, evt_id); end
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    n_vec++; if (pend !== 4'b0000 || overrun !== 4'b0000 || evt_valid !== 1'b0) begin n_err++; $display("FAIL clr_all: got pend=%b ovr=%b v=%b want 0/0/0", pend, overrun, evt_valid); end
    tick();
    n_vec++; if (irq !== 1'b0 || evt_valid !== 1'b0) begin n_err++; $display("FAIL clr_after: got irq=%b v=%b want 0/0", irq, evt_valid); end
  endtask

  task automatic test_mask_reset();
    en_mask = 4'b0111; deb_cycles = 8'd3;
    do_reset();
    sensor = 4'b1000;
    repeat (10) tick();
    n_vec++; if (pend !== 4'b0000 || evt_valid !== 1'b0) begin n_err++; $display("FAIL mask3: got pend=%b v=%b want 0000/0", pend, evt_valid); end
    sensor = 4'b1001;
    repeat (8) tick();
    n_vec++; if (evt_valid !== 1'b1 || evt_id !== 2'd0 || pend !== 4'b0001) begin n_err++; $display("FAIL mask_ev0: got v=%b id=%0d pend=%b want 1/0/0001", evt_valid, evt_id, pend); end
    en_mask = 4'b0110;
    tick();
    n_vec++; if (pend !== 4'b0001) begin n_err++; $display("FAIL unarm_keeps_pend: got %b want 0001", pend); end
    rst = 1'b0;
    tick();
    n_vec++; if (evt_valid !== 1'b0 || evt_id !== 2'd0 || pend !== 4'b0000 || overrun !== 4'b0000 || irq !== 1'b0) begin
      n_err++; $display("FAIL rst_present: got v=%b id=%0d pend=%b ovr=%b irq=%b want all 0", evt_valid, evt_id, pend, overrun, irq);
    end
    en_mask = 4'b0111;
    rst = 1'b1;
    repeat (6) tick();
    n_vec++; if (pend !== 4'b0000) begin n_err++; $display("FAIL held_e6: got %b want 0000", pend); end
    tick();
    n_vec++; if (pend !== 4'b0001) begin n_err++; $display("FAIL held_e7: got %b want 0001", pend); end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 3; seg++) begin
      en_mask = 4'(($urandom));
      deb_cycles = DW'($urandom_range(0, 5));
      do_reset();
      for (int c = 0; c < 500; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 5) == 0) sensor[i] = ~sensor[i];
        if ($urandom_range(0, 19) == 0) en_mask = 4'($urandom);
        evt_ready = 1'($urandom_range(0, 1));
        clr_all   = ($urandom_range(0, 49) == 0);
        rst       = ($urandom_range(0, 199) != 0);
        tick();
        n_vec++;
        if (evt_valid !== pres_m || (pres_m && evt_id !== IW'(id_m)) || pend !== pend_m ||
            overrun !== ovr_m || irq !== irq_m) begin
          n_err++;
          $display("FAIL rand_s%0d_c%0d: got v=%b id=%0d pend=%b ovr=%b irq=%b want v=%b id=%0d pend=%b ovr=%b irq=%b",
                   seg, c, evt_valid, evt_id, pend, overrun, irq, pres_m, id_m, pend_m, ovr_m, irq_m);
        end
      end
      rst = 1'b1; clr_all = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0; sensor = '0; en_mask = '0; deb_cycles = 8'd3; clr_all = 1'b0; evt_ready = 1'b0;
    test_reset();
    test_latency();
    test_glitch();
    test_rr_order();
    test_overrun_clr();
    test_mask_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
